// File: rtl/fft_pkg.sv
// Shared definitions for the FFT pipeline controller and its datapath:
// controller states, default geometry and the complex lane count.
package fft_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fft_state_t;

   localparam int FFT_NSTAGE_DEF = 5;
   localparam int FFT_CW_DEF     = 16;
   localparam int FFT_LANES      = 32;

endpackage

// File: rtl/fft_vld_pipe.sv
// Valid-token shift register that mirrors the FFT datapath stage registers.
// All stages load together on en; flush empties the whole chain on the next edge.
module fft_vld_pipe #(
   parameter int NSTAGE = 5
) (
   input  logic              clk,
   input  logic              arstb,
   input  logic              en,
   input  logic              flush,
   input  logic              din,
   output logic [NSTAGE-1:0] vld
);

   // Bit 0 takes the newly accepted token, higher bits follow the stage chain.
   always_ff @(posedge clk or negedge arstb) begin
      if (!arstb) begin
         vld <= '0;
      end else if (flush) begin
         vld <= '0;
      end else if (en) begin
         vld <= (vld << 1) | NSTAGE'(din);
      end
   end

endmodule

// File: rtl/fft_pipe_ctrl.sv
// Job sequencer for the FFT stage chain: valid/ready flow control, common stage enable,
// frame counting and done/abort reporting. Define FFT_CTRL_PERF_EN to add the stall_cnt output.
module fft_pipe_ctrl
   import fft_pkg::*;
#(
   parameter int NSTAGE = FFT_NSTAGE_DEF,
   parameter int CW     = FFT_CW_DEF
) (
   input  logic              clk,
   input  logic              arstb,
   input  logic              rstb,
   input  logic              start,
   input  logic [CW-1:0]     cfg_nframes,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              out_ready,
   output logic              out_valid,
   output logic              stage_en,
   output logic [NSTAGE-1:0] stage_vld,
   output logic              busy,
   output logic              done,
   output logic              done_abort
`ifdef FFT_CTRL_PERF_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   fft_state_t    state;
   logic [CW-1:0] acc_cnt;
   logic [CW-1:0] out_cnt;
   logic [CW-1:0] nframes_q;
   logic [CW-1:0] last_idx;
   logic          advance;
   logic          in_hs;
   logic          out_hs;
   logic          flush;

   // The whole chain moves unless the last stage holds a frame the sink refuses.
   assign advance   = !stage_vld[NSTAGE-1] | out_ready;
   assign stage_en  = advance;
   assign out_valid = stage_vld[NSTAGE-1];
   assign busy      = (state != IDLE);
   assign in_ready  = (state == RUN) & advance;
   assign in_hs     = in_valid & in_ready;
   assign out_hs    = out_valid & out_ready;
   assign last_idx  = nframes_q - CW'(1);
   assign flush     = !rstb | (busy & abort);

   fft_vld_pipe #(
      .NSTAGE (NSTAGE)
   ) u_vld_pipe (
      .clk   (clk),
      .arstb (arstb),
      .en    (advance),
      .flush (flush),
      .din   (in_hs),
      .vld   (stage_vld)
   );

   // Job FSM with frame counters; an abort while busy discards that cycle's handshakes.
   always_ff @(posedge clk or negedge arstb) begin
      if (!arstb) begin
         state      <= IDLE;
         acc_cnt    <= '0;
         out_cnt    <= '0;
         nframes_q  <= '0;
         done       <= 1'b0;
         done_abort <= 1'b0;
      end else if (!rstb) begin
         state      <= IDLE;
         acc_cnt    <= '0;
         out_cnt    <= '0;
         nframes_q  <= '0;
         done       <= 1'b0;
         done_abort <= 1'b0;
      end else begin
         done       <= 1'b0;
         done_abort <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (cfg_nframes != '0) begin
                     nframes_q <= cfg_nframes;
                     acc_cnt   <= '0;
                     out_cnt   <= '0;
                     state     <= RUN;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            RUN, DRAIN: begin
               if (abort) begin
                  state      <= IDLE;
                  done       <= 1'b1;
                  done_abort <= 1'b1;
               end else begin
                  if (in_hs) begin
                     acc_cnt <= acc_cnt + CW'(1);
                  end
                  if (out_hs) begin
                     out_cnt <= out_cnt + CW'(1);
                  end
                  if (state == RUN && in_hs && acc_cnt == last_idx) begin
                     state <= DRAIN;
                  end
                  if (state == DRAIN && out_hs && out_cnt == last_idx) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef FFT_CTRL_PERF_EN
   // Saturating count of cycles where a busy job is blocked by the sink.
   always_ff @(posedge clk or negedge arstb) begin
      if (!arstb) begin
         stall_cnt <= '0;
      end else if (!rstb) begin
         stall_cnt <= '0;
      end else if (state == IDLE && start) begin
         stall_cnt <= '0;
      end else if (busy && out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/fft_pipe_ctrl.md
Name: fft_pipe_ctrl

Overview:
Sequencing controller for the 32-point FFT datapath pipeline registers (32 complex lanes per stage). Accepts a job of N frames, applies valid/ready flow control, and generates a common stage enable that the datapath registers use to load or hold. It tracks the valid token in each stage, counts frames in and out, and signals job completion or abort. It sits between the sample-frame source, the FFT stage chain and the result sink.

Parameters:
NSTAGE, 5, number of pipeline register stages in the FFT chain (≥1)
CW, 16, width of the frame counters and cfg_nframes

Ports:
clk  in  1  clock
arstb  in  1  asynchronous active-low reset
rstb  in  1  synchronous active-low clear; same effect as arstb, applied on the clk edge
start  in  1  job start pulse; sampled only in IDLE
cfg_nframes  in  CW  frames in the job; sampled with start
abort  in  1  synchronous abort
in_valid  in  1  input frame valid
in_ready  out  1  controller accepts the input frame
out_ready  in  1  sink accepts the output frame
out_valid  out  1  valid frame present at the last stage
stage_en  out  1  common load enable for all datapath stage registers
stage_vld  out  NSTAGE  per-stage valid bits; bit i is stage i
busy  out  1  controller is in RUN or DRAIN
done  out  1  one-cycle pulse at job end
done_abort  out  1  qualifies done; set when the job ended by abort
stall_cnt  out  32  present only when FFT_CTRL_PERF_EN is defined

Behaviour:
- Reset (arstb low asynchronously, or rstb low at the clk edge) forces:
  - state = IDLE; stage_vld = 0
  - acc_cnt = out_cnt = nframes_q = 0
  - in_ready = out_valid = busy = done = done_abort = 0
  - stage_en = 1 (combinationally, from stage_vld = 0)
- advance = !stage_vld[NSTAGE-1] | out_ready; stage_en = advance. All stages load or hold together; there are no bubble-collapse stages.
- out_valid = stage_vld[NSTAGE-1].
- in_ready = (state == RUN) & advance.
- Valid pipeline, when advance is 1:
  - stage_vld[0] <= in_valid & in_ready
  - stage_vld[i] <= stage_vld[i-1] for each i ≥ 1
  - When advance is 0, all valid bits hold.
- Latency: a frame accepted at edge t is out_valid after edge t+NSTAGE-1 (visible from cycle t+NSTAGE), provided there are no stalls. Throughput is 1 frame per cycle.
- Each stall cycle (out_valid & !out_ready) adds exactly one cycle of latency to every in-flight frame.
- Input handshake: in_valid & in_ready increments acc_cnt. Output handshake: out_valid & out_ready increments out_cnt.
- States are IDLE, RUN, DRAIN, encoded as 2 bits. Transitions:
  - IDLE, start, cfg_nframes ≠ 0: latch nframes_q, clear both counters, go to RUN.
  - IDLE, start, cfg_nframes = 0: done = 1 next cycle, done_abort = 0, stay in IDLE.
  - RUN, input handshake with acc_cnt == nframes_q-1: go to DRAIN.
  - DRAIN, output handshake with out_cnt == nframes_q-1: go to IDLE, done = 1.
  - RUN or DRAIN, abort: on the next edge clear all stage_vld and go to IDLE; done = 1 and done_abort = 1. Any handshakes in that cycle are discarded.
- In RUN, outputs drain concurrently with inputs, so the last output can never precede the last input.
- Simultaneous events:
  - abort has priority over everything else, including a DRAIN completion in the same cycle (result is done_abort = 1).
  - start is ignored outside IDLE.
  - abort in IDLE is ignored, and start in that same cycle is still honoured.
- A reset mid-job drops all in-flight frames silently, with no done pulse.
- Counters never wrap within a job, because nframes_q ≤ 2^CW-1.
- done and done_abort are registered and held for exactly one cycle.

Optional Feature:
FFT_CTRL_PERF_EN:
- Defined: adds the 32-bit stall_cnt output. It increments on every cycle with busy & out_valid & !out_ready, saturates at 0xFFFFFFFF, clears on an accepted start, and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fft_pkg holds:
  - state typedef/localparams: IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2
  - default NSTAGE = 5 and CW = 16
  - the lane count (32) shared with the datapath
- One sub-module, fft_vld_pipe: the NSTAGE-deep valid shift register with enable and a synchronous flush input. It is instanced once; the FSM and counters stay at top level.

Test Plan:
- Reset then idle: after arstb release, stage_vld = 0, in_ready = 0, stage_en = 1, done = 0 for 10 cycles.
- Job of 4 frames, no stalls (cfg_nframes = 4, in_valid = 1, out_ready = 1): first out_valid 5 cycles after the first accept; 4 output handshakes; done pulses once in the cycle after the 4th output; done_abort = 0.
- Backpressure: same job with out_ready = 0 for 3 cycles while stage 4 is valid: stage_en = 0, in_ready = 0, stage_vld frozen, frame order preserved; done is 3 cycles later than the no-stall case (stall_cnt = 3 with FFT_CTRL_PERF_EN).
- Abort mid-job: cfg_nframes = 10, abort after the 6th accept: next cycle stage_vld = 0, state IDLE, done = 1 with done_abort = 1; a subsequent start is accepted.
- Boundary start: start with cfg_nframes = 0 gives an immediate done with done_abort = 0 and no in_ready; start during RUN is ignored (nframes_q unchanged).
- rstb pulsed low mid-DRAIN: next edge clears all state, and no done pulse occurs.
